// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, special instruction words,
// and the legal-PC helper used when accepting a new PC.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 -- what a bubble or squashed slot looks like to decode.
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  // Only meaningful when halt detection is built in.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // A PC is usable when it is word aligned and below the end of memory.
  function automatic logic is_legal_pc(input logic [31:0] addr,
                                       input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_pipe_reg.sv
// IF/ID pipeline register with load / hold / squash controls.
// Latency: one clock from load to outputs. Squash beats load; neither means hold.
// Reusable for later pipeline registers that need the same three behaviours.
module ifid_pipe_reg #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Squash inserts a bubble, load captures a real instruction, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (squash) begin
      instruction <= NOP;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instruction_in;
      pc_plus4    <= pc_plus4_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses a zero-latency ROM, fills IF/ID.
// Latency: ROM word sampled the same cycle, visible in IF/ID after one edge.
// Stall holds PC and IF/ID; Redirect overrides Stall. Optional halt detection
// is compiled in with IFU_HALT_DETECT_EN (adds the Halted port).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP        = NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        FetchFault,
`ifdef IFU_HALT_DETECT_EN
  output logic        Halted,
`endif
  output logic [31:0] PC
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q, pc_nxt, pc_plus4;
  logic         fault_q, fault_nxt;
  logic         ifid_load, ifid_squash;
  logic         target_legal;

  assign pc_plus4     = pc_q + 32'd4;  // modulo 2^32, carry dropped
  assign target_legal = is_legal_pc(RedirectTarget, PC_LIMIT);

  assign ImemAddress = pc_q;
  assign PC          = pc_q;
  assign FetchFault  = fault_q;
`ifdef IFU_HALT_DETECT_EN
  assign Halted      = (state == ST_HALT);
`endif

  // State, PC and sticky fault flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      fault_q <= fault_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    fault_nxt   = fault_q;
    ifid_load   = 1'b0;
    ifid_squash = 1'b0;
    case (state)
      ST_RUN: begin
        if (Redirect) begin
          // The word fetched this cycle is wrong-path; drop it.
          pc_nxt      = RedirectTarget;
          ifid_squash = 1'b1;
          if (!target_legal) begin
            fault_nxt = 1'b1;
            state_nxt = ST_FAULT;
          end
        end else if (!Stall) begin
          ifid_load = 1'b1;
`ifdef IFU_HALT_DETECT_EN
          if (ImemInstruction == HALT_WORD) begin
            // Keep PC on the halt word so a debugger sees where it stopped.
            state_nxt = ST_HALT;
          end else
`endif
          begin
            pc_nxt = pc_plus4;
            // The last word is still delivered; only the next PC is bad.
            if (pc_plus4 >= PC_LIMIT) begin
              fault_nxt = 1'b1;
              state_nxt = ST_FAULT;
            end
          end
        end
      end
      ST_FAULT: begin
        if (Redirect && target_legal) begin
          pc_nxt      = RedirectTarget;
          fault_nxt   = 1'b0;
          state_nxt   = ST_RUN;
          ifid_squash = 1'b1;
        end else if (!Stall) begin
          ifid_squash = 1'b1;
        end
      end
`ifdef IFU_HALT_DETECT_EN
      ST_HALT: begin
        // Terminal until reset: Stall and Redirect are ignored.
        ifid_squash = 1'b1;
      end
`endif
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  ifid_pipe_reg #(
    .NOP(NOP)
  ) u_ifid (
    .clk           (Clk),
    .rst           (Reset),
    .load          (ifid_load),
    .squash        (ifid_squash),
    .instruction_in(ImemInstruction),
    .pc_plus4_in   (pc_plus4),
    .instruction   (IFID_Instruction),
    .pc_plus4      (IFID_PCPlus4),
    .valid         (IFID_Valid)
  );

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface. Owns the PC and drives the word address into the combinational instruction ROM (1024 x 32, indexed by Address[11:2]).
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, and fetch-fault detection (misaligned or out-of-range PC).
- Sits between hazard/branch logic and the decode stage of the MIPS pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; legal PC range is 0 .. IMEM_WORDS*4-4.
- NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on bubble/squash (sll $0,$0,0).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold PC and IF/ID (load-use hazard).
- Redirect  input  1  take RedirectTarget (branch/jump resolved).
- RedirectTarget  input  32  new PC on Redirect.
- ImemAddress  output  32  byte address to instruction memory; equals PC.
- ImemInstruction  input  32  word returned by instruction memory, same cycle.
- IFID_Instruction  output  32  registered instruction.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction.
- FetchFault  output  1  sticky fault flag.
- PC  output  32  current PC (debug).

Behaviour:
- Reset (async, active-high):
  - PC=RESET_PC; IFID_Instruction=NOP_WORD; IFID_PCPlus4=0; IFID_Valid=0; FetchFault=0; state=RUN.
- ImemAddress = PC, combinational. The instruction is sampled the same cycle (zero-latency ROM).
- FSM states: RUN, FAULT (HALT added by the optional feature).
- RUN, per rising edge, in priority order:
  1. Redirect=1, target legal: PC<=RedirectTarget; IF/ID<=NOP_WORD, Valid=0 (squash the wrong-path fetch). Redirect overrides Stall in the same cycle.
  2. Redirect=1, target illegal (bits[1:0]!=0, or target >= IMEM_WORDS*4): PC<=RedirectTarget; IF/ID squashed; FetchFault<=1; state<=FAULT.
  3. Stall=1: PC, IF/ID, Valid all hold.
  4. Otherwise: IF/ID<=ImemInstruction; IFID_PCPlus4<=PC+4; Valid<=1; PC<=PC+4.
- PC arithmetic is 32-bit modulo; carry is dropped.
- Sequential overflow:
  - If PC+4 >= IMEM_WORDS*4, the current word is still captured (Valid=1).
  - PC is then updated, FetchFault<=1, and state<=FAULT on the same edge.
- FAULT:
  - PC holds; IF/ID loads NOP_WORD with Valid=0 every non-stalled cycle.
  - Leaves FAULT only on Redirect to a legal target: FetchFault<=0, state<=RUN, PC<=target, IF/ID squashed. Reset also exits.
  - Stall in FAULT has no effect beyond holding IF/ID.
- Reset asserted mid-cycle clears everything immediately; no partial capture.

Optional Feature:
- Macro IFU_HALT_DETECT_EN.
- With the macro defined:
  - A captured instruction equal to 32'hFFFF_FFFF causes state<=HALT on the capture edge. That word enters IF/ID with Valid=1; PC is not advanced past it.
  - In HALT, PC holds and IF/ID loads NOP_WORD with Valid=0. Stall and Redirect are ignored; only Reset exits.
  - Extra output port Halted (1 bit, 1 in HALT, reset 0).
- Without the macro:
  - 32'hFFFF_FFFF is fetched like any other word.
  - The Halted port does not exist.

Decomposition:
- Shared package: fetch state encoding (ST_RUN, ST_FAULT, ST_HALT); NOP_WORD, HALT_WORD constants; an is-legal-PC helper function.
- One natural sub-module: ifid_pipe_reg, the IF/ID register with load/hold/squash controls, reused by later pipeline registers.

Test Plan:
- Reset, then 4 free cycles with ROM[i]=i*3 → IFID_Instruction 0,3,6,9; IFID_PCPlus4 4,8,12,16; PC=0x10.
- Stall held 2 cycles at PC=0x8 → PC stays 0x8; IF/ID holds word 3 with Valid=1; release resumes with word 6.
- Redirect=1, Stall=1, RedirectTarget=0x40 → next cycle PC=0x40, Valid=0; the following cycle captures ROM[16]=48.
- Redirect to 0x42 → FetchFault=1, Valid stays 0; then Redirect to 0x20 → FetchFault=0, ROM[8]=24 fetched.
- Run PC to 0xFFC → word 3069 captured, FetchFault=1; Reset asserted asynchronously mid-cycle → PC=0 and all outputs reset before the next edge.
- (IFU_HALT_DETECT_EN) ROM[5]=0xFFFFFFFF → Halted=1, PC stays 0x14, later Redirect ignored until Reset.
